// File: rtl/tlb_unit.sv
// Fully associative joint TLB: entry read/probe/write for CP0, plus two
// independent single-cycle-latency translation ports (fetch and data).
package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_unit #(
    parameter int unsigned TLB_ENTRIES_NUM = 16,
    parameter int unsigned IDX_W           = $clog2(TLB_ENTRIES_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             asid,
    input  logic                   i_req,
    input  logic [31:0]            i_vaddr,
    output logic [31:0]            i_paddr,
    output logic                   i_valid,
    output logic                   i_miss,
    output logic                   i_invalid,
    output logic                   i_uncached,
    input  logic                   d_req,
    input  logic [31:0]            d_vaddr,
    output logic [31:0]            d_paddr,
    output logic                   d_valid,
    output logic                   d_miss,
    output logic                   d_invalid,
    output logic                   d_uncached,
    output logic                   d_dirty,
    input  logic [IDX_W-1:0]       tlbr_idx,
    output tlb_pkg::tlb_entry_t    tlbr_res,
    input  logic                   tlbp_req,
    input  logic [18:0]            tlbp_vpn2,
    output logic [31:0]            tlbp_res,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  tlb_pkg::tlb_entry_t    wentry
);
    import tlb_pkg::*;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } page_t;

    tlb_entry_t entries [TLB_ENTRIES_NUM];

    logic [IDX_W:0] i_m, d_m, p_m;
    page_t          i_pg, d_pg;
    logic           unused;

    // Returns {hit, index}; scanning upward and keeping the first hit makes
    // the lowest matching index win on overlapping entries.
    function automatic logic [IDX_W:0] find(input logic [18:0] vpn, input logic [7:0] a);
        logic [IDX_W:0] r;
        r = '0;
        for (int unsigned k = 0; k < TLB_ENTRIES_NUM; k++) begin
            if (!r[IDX_W] && entries[k].vpn2 == vpn && (entries[k].g || entries[k].asid == a))
                r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    function automatic page_t pick(input tlb_entry_t e, input logic odd);
        return odd ? page_t'{e.pfn1, e.c1, e.d1, e.v1} : page_t'{e.pfn0, e.c0, e.d0, e.v0};
    endfunction

    always_comb begin
        i_m  = find(i_vaddr[31:13], asid);
        d_m  = find(d_vaddr[31:13], asid);
        p_m  = find(tlbp_vpn2, asid);
        i_pg = pick(entries[i_m[IDX_W-1:0]], i_vaddr[12]);
        d_pg = pick(entries[d_m[IDX_W-1:0]], d_vaddr[12]);
        tlbr_res = entries[tlbr_idx];
        tlbp_res = p_m[IDX_W] ? {{(32-IDX_W){1'b0}}, p_m[IDX_W-1:0]} : 32'h8000_0000;
    end

    // The probe strobe only qualifies CP0's use of the result.
    assign unused = tlbp_req ^ i_pg.d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TLB_ENTRIES_NUM; k++)
                entries[k] <= '0;
        end else if (we) begin
            entries[widx] <= wentry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid    <= 1'b0;
            i_paddr    <= '0;
            i_miss     <= 1'b0;
            i_invalid  <= 1'b0;
            i_uncached <= 1'b0;
        end else begin
            i_valid <= i_req;
            if (i_req) begin
                i_paddr    <= i_m[IDX_W] ? {i_pg.pfn, i_vaddr[11:0]} : '0;
                i_miss     <= ~i_m[IDX_W];
                i_invalid  <= i_m[IDX_W] & ~i_pg.v;
                i_uncached <= i_m[IDX_W] & (i_pg.c == 3'd2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid    <= 1'b0;
            d_paddr    <= '0;
            d_miss     <= 1'b0;
            d_invalid  <= 1'b0;
            d_uncached <= 1'b0;
            d_dirty    <= 1'b0;
        end else begin
            d_valid <= d_req;
            if (d_req) begin
                d_paddr    <= d_m[IDX_W] ? {d_pg.pfn, d_vaddr[11:0]} : '0;
                d_miss     <= ~d_m[IDX_W];
                d_invalid  <= d_m[IDX_W] & ~d_pg.v;
                d_uncached <= d_m[IDX_W] & (d_pg.c == 3'd2);
                d_dirty    <= d_m[IDX_W] & d_pg.d;
            end
        end
    end

endmodule
